// File: rtl/abcd_stim_gen.sv
`default_nettype none
// ============================================================================
//  Module   : abcd_stim_gen
//  Purpose  : Stimulus sequencer driving a/b/c/d into the immediate-assertion
//             checker, with a registered prediction of the checker outcome.
//  Revision : 1.0 - initial release
// ============================================================================
module abcd_stim_gen #(
    parameter int DLY_W = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [DLY_W-1:0] a_to_d_dly,
    input  logic [DLY_W-1:0] hold_len,
    input  logic [1:0]       bc_mode,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             d,
    output logic             busy,
    output logic             done,
    output logic             expect_pass,
    output logic [CNT_W-1:0] run_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_D = 2'd1,
        HOLD   = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t           r_state;
    logic [DLY_W-1:0] r_cnt;
    logic [DLY_W-1:0] r_hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_hold      <= '0;
            a           <= 1'b0;
            b           <= 1'b0;
            c           <= 1'b0;
            d           <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            expect_pass <= 1'b0;
            run_count   <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    busy <= 1'b0;
                    if (start && !abort) begin
                        r_cnt       <= a_to_d_dly;
                        r_hold      <= hold_len;
                        a           <= 1'b1;
                        b           <= bc_mode[1];
                        c           <= bc_mode[0];
                        expect_pass <= bc_mode[1] | bc_mode[0];
                        busy        <= 1'b1;
                        r_state     <= WAIT_D;
                    end
                end
                WAIT_D: begin
                    if (abort) begin
                        a           <= 1'b0;
                        b           <= 1'b0;
                        c           <= 1'b0;
                        d           <= 1'b0;
                        expect_pass <= 1'b0;
                        busy        <= 1'b0;
                        r_cnt       <= '0;
                        r_state     <= IDLE;
                    end else if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        d       <= 1'b1;
                        r_cnt   <= r_hold;
                        r_state <= HOLD;
                    end
                end
                HOLD: begin
                    if (abort) begin
                        a           <= 1'b0;
                        b           <= 1'b0;
                        c           <= 1'b0;
                        d           <= 1'b0;
                        expect_pass <= 1'b0;
                        busy        <= 1'b0;
                        r_cnt       <= '0;
                        r_state     <= IDLE;
                    end else if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        // Completion is registered on entry so done/run_count are valid during DONE
                        a           <= 1'b0;
                        b           <= 1'b0;
                        c           <= 1'b0;
                        d           <= 1'b0;
                        expect_pass <= 1'b0;
                        done        <= 1'b1;
                        run_count   <= run_count + 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_abcd_stim_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_abcd_stim_gen
//  Purpose  : Directed self-checking bench for abcd_stim_gen (CNT_W = 2).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_abcd_stim_gen;

    localparam int DLY_W = 8;
    localparam int CNT_W = 2;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             abort;
    logic [DLY_W-1:0] a_to_d_dly;
    logic [DLY_W-1:0] hold_len;
    logic [1:0]       bc_mode;
    logic             a, b, c, d, busy, done, expect_pass;
    logic [CNT_W-1:0] run_count;

    int               checks;
    int               errors;
    logic [CNT_W-1:0] exp_cnt;

    abcd_stim_gen #(.DLY_W(DLY_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .a_to_d_dly  (a_to_d_dly),
        .hold_len    (hold_len),
        .bc_mode     (bc_mode),
        .a           (a),
        .b           (b),
        .c           (c),
        .d           (d),
        .busy        (busy),
        .done        (done),
        .expect_pass (expect_pass),
        .run_count   (run_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output vector order: {a, b, c, d, busy, done, expect_pass}
    task automatic test_reset();
        logic [6:0] act;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        a_to_d_dly = '0; hold_len = '0; bc_mode = 2'b00;
        exp_cnt = '0;
        repeat (3) @(negedge clk);
        act = {a, b, c, d, busy, done, expect_pass};
        checks++;
        if (act !== 7'b0) begin
            errors++; $display("FAIL reset_outputs: got %b expected %b", act, 7'b0);
        end
        checks++;
        if (run_count !== 2'd0) begin
            errors++; $display("FAIL reset_count: got %0d expected 0", run_count);
        end
        rst_n = 1'b1;
        @(negedge clk);
        act = {a, b, c, d, busy, done, expect_pass};
        checks++;
        if (act !== 7'b0) begin
            errors++; $display("FAIL reset_release_idle: got %b expected %b", act, 7'b0);
        end
    endtask

    // Called just after a negedge; returns on the first IDLE cycle after DONE
    task automatic run_check(input logic [7:0] dly, input logic [7:0] hold,
                             input logic [1:0] mode, input bit disturb, input string name);
        int         t;
        logic [6:0] exp, act;
        t = int'(dly) + int'(hold);
        a_to_d_dly = dly; hold_len = hold; bc_mode = mode; start = 1'b1;
        for (int k = 1; k <= t + 4; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (disturb && k == int'(dly) + 2) begin
                start = 1'b1; bc_mode = ~mode; a_to_d_dly = 8'd0; hold_len = 8'd0;
            end
            if (k <= t + 2)
                exp = {1'b1, mode[1], mode[0], (k >= int'(dly) + 2), 1'b1, 1'b0, |mode};
            else if (k == t + 3)
                exp = 7'b0000110;
            else
                exp = 7'b0;
            act = {a, b, c, d, busy, done, expect_pass};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL %s cycle %0d: got %b expected %b", name, k, act, exp);
            end
            if (k == t + 3) begin
                exp_cnt = exp_cnt + 1'b1;
                checks++;
                if (run_count !== exp_cnt) begin
                    errors++;
                    $display("FAIL %s run_count: got %0d expected %0d", name, run_count, exp_cnt);
                end
            end
        end
    endtask

    task automatic test_abort();
        logic [6:0] act;
        a_to_d_dly = 8'd5; hold_len = 8'd1; bc_mode = 2'b11; start = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        act = {a, b, c, d, busy, done, expect_pass};
        checks++;
        if (act !== 7'b1110101) begin
            errors++; $display("FAIL abort_wait_d_state: got %b expected %b", act, 7'b1110101);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        act = {a, b, c, d, busy, done, expect_pass};
        checks++;
        if (act !== 7'b0) begin
            errors++; $display("FAIL abort_clears: got %b expected %b", act, 7'b0);
        end
        repeat (8) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || done !== 1'b0 || d !== 1'b0) begin
                errors++; $display("FAIL abort_stays_idle: busy %b done %b d %b expected 0", busy, done, d);
            end
        end
        checks++;
        if (run_count !== exp_cnt) begin
            errors++; $display("FAIL abort_count: got %0d expected %0d", run_count, exp_cnt);
        end
    endtask

    task automatic test_abort_vs_start();
        logic [6:0] act;
        bc_mode = 2'b10; a_to_d_dly = 8'd0; hold_len = 8'd0;
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        act = {a, b, c, d, busy, done, expect_pass};
        checks++;
        if (act !== 7'b0) begin
            errors++; $display("FAIL abort_beats_start: got %b expected %b", act, 7'b0);
        end
    endtask

    task automatic test_async_reset();
        logic [6:0] act;
        a_to_d_dly = 8'd1; hold_len = 8'd4; bc_mode = 2'b11; start = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        checks++;
        if (d !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL async_reset_in_hold: d %b busy %b expected 1 1", d, busy);
        end
        #2 rst_n = 1'b0;
        #1;
        act = {a, b, c, d, busy, done, expect_pass};
        exp_cnt = '0;
        checks++;
        if (act !== 7'b0 || run_count !== 2'd0) begin
            errors++; $display("FAIL async_reset_immediate: got %b cnt %0d expected %b cnt 0", act, run_count, 7'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        act = {a, b, c, d, busy, done, expect_pass};
        checks++;
        if (act !== 7'b0) begin
            errors++; $display("FAIL async_reset_idle_after: got %b expected %b", act, 7'b0);
        end
    endtask

    task automatic test_back_to_back();
        run_check(8'd1, 8'd0, 2'b11, 1'b0, "b2b_run1");
        run_check(8'd0, 8'd1, 2'b01, 1'b0, "b2b_run2");
        run_check(8'd2, 8'd0, 2'b10, 1'b0, "b2b_run3");
        run_check(8'd0, 8'd0, 2'b00, 1'b0, "b2b_run4_wrap");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        run_check(8'd0, 8'd0, 2'b00, 1'b0, "min_run");
        run_check(8'd3, 8'd2, 2'b10, 1'b0, "delay_hold");
        test_abort();
        test_abort_vs_start();
        run_check(8'd1, 8'd1, 2'b01, 1'b0, "after_abort");
        run_check(8'd2, 8'd2, 2'b01, 1'b1, "start_during_hold");
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0) begin
                errors++; $display("FAIL ignored_start_no_run: busy %b expected 0", busy);
            end
        end
        test_async_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/abcd_stim_gen.md
Name: abcd_stim_gen

Overview:
- Synthesizable stimulus sequencer that sits directly upstream of the a/b/c/d immediate-assertion checker and drives its four inputs.
- Each run: raise a, set b/c to a programmed pattern, raise d after a programmable delay, hold, then release.
- Reports the checker outcome it expects (expect_pass = b|c), so a scoreboard can compare it with the checker's pass/fail messages.
- Used by lab benches and the regression bench to generate repeatable pass and fail cases.

Parameters:
- DLY_W, 8, width of the a-to-d delay and hold-length fields.
- CNT_W, 8, width of the completed-run counter.

Ports:
- clk  in  1  system clock, all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to begin a run; sampled only in IDLE.
- abort  in  1  synchronous abort of the current run.
- a_to_d_dly  in  DLY_W  number of extra cycles between a rising and d rising.
- hold_len  in  DLY_W  number of extra cycles d stays high.
- bc_mode  in  2  pattern: bit1 -> b, bit0 -> c.
- a  out  1  checker trigger.
- b  out  1  checker operand.
- c  out  1  checker operand.
- d  out  1  checker event strobe.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a run completes normally.
- expect_pass  out  1  registered b|c for the current run; 0 in IDLE.
- run_count  out  CNT_W  number of completed runs; wraps modulo 2^CNT_W.

Behaviour:
- Reset (async assert, sync release): state=IDLE; a, b, c, d, busy, done, expect_pass = 0; run_count = 0; internal counter = 0.
- All outputs are registered; no combinational path from any input to any output.
- States: IDLE, WAIT_D, HOLD, DONE.
- IDLE:
  - start=1 and abort=0: latch a_to_d_dly into cnt, latch hold_len into hold_reg, go to WAIT_D.
  - In the same cycle, register a=1, b=bc_mode[1], c=bc_mode[0], expect_pass=bc_mode[1]|bc_mode[0].
- WAIT_D:
  - cnt!=0: decrement cnt.
  - cnt==0: register d=1, load cnt=hold_reg, go to HOLD.
  - d therefore rises exactly a_to_d_dly+1 cycles after a rises.
  - b and c are always stable at least one full cycle before d rises.
- HOLD:
  - cnt!=0: decrement cnt.
  - cnt==0: clear a, b, c, d and go to DONE.
  - d is high for exactly hold_len+1 cycles.
  - a, b and c stay constant throughout HOLD.
- DONE: for one cycle, done=1, run_count increments (wraps, no saturation), expect_pass cleared; then go to IDLE.
  - busy is still 1 in DONE and drops on return to IDLE.
  - Back-to-back: the earliest start is accepted on the cycle after DONE.
- Config inputs are latched on start. Later changes do not affect a run in progress.
- start while busy: ignored, not queued.
- abort:
  - In WAIT_D or HOLD: next cycle a, b, c, d, expect_pass = 0, state=IDLE, no done pulse, run_count unchanged.
  - In DONE: the DONE actions still complete (done pulses, count increments).
  - In IDLE with start in the same cycle: abort wins, no run starts.
- Wrap-around: run_count at 2^CNT_W-1 plus one completion gives 0.
- Reset mid-run: all outputs return to reset values immediately (asynchronously); no done pulse.

Test Plan:
- Reset, start with a_to_d_dly=0, hold_len=0, bc_mode=00 -> a rises cycle 1, d rises cycle 2 and is high 1 cycle, expect_pass=0 (checker must fail), done at cycle 3, run_count=1.
- a_to_d_dly=3, hold_len=2, bc_mode=10 -> d rises 4 cycles after a, d high 3 cycles, b=1 and c=0 throughout, expect_pass=1, done once.
- Assert abort while in WAIT_D (a_to_d_dly=5, abort at cycle 3) -> all outputs 0 next cycle, no done, run_count unchanged; start then accepted normally.
- Pulse start again during HOLD; also change bc_mode mid-run -> second start ignored, b/c keep the latched values, exactly one done.
- CNT_W=2: four back-to-back runs, each started the cycle after DONE -> run_count sequence 1,2,3,0; busy drops for exactly one cycle between runs.
- Assert rst_n low mid-HOLD between clock edges -> a, b, c, d, busy drop to 0 without waiting for a clock edge; state is IDLE after release.
